uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//   Receive-side buffer between UartRx and the CPU-facing I/O register file.
//   Runs the UartRx go/dr handshake continuously and stores each received byte
//   in a circular FIFO, so bytes are not lost while the CPU is busy.
//   The I/O register file pops one byte per UART-in read. It sees first-word
//   fall-through data, an empty flag and a sticky overflow flag.
// PARAMETERS
//   DEPTH_BITWIDTH  4  log2 of FIFO depth; default depth = 16 bytes
// PORTS
//   clk          in   1    single clock; all state updates on posedge
//   rst          in   1    asynchronous, active-high reset
//   uart_data    in   8    byte from UartRx; valid while uart_dr=1
//   uart_dr      in   1    UartRx data ready
//   uart_go      out  1    to UartRx: 1 = receive, 0 = acknowledge dr
//   rd           in   1    pop head entry (one byte per cycle asserted)
//   dout         out  8    head entry (fall-through); 8'h00 when empty
//   empty        out  1    FIFO holds 0 entries
//   full         out  1    FIFO holds 2^DEPTH_BITWIDTH entries
//   count        out  DEPTH_BITWIDTH+1  number of stored entries
//   overflow     out  1    sticky: a received byte was dropped
//   overflow_clr in   1    clears overflow
// BEHAVIOUR
//   Reset (async, rst=1):
//   - wr_ptr=rd_ptr=count=0, state=LISTEN, uart_go=1, dout=0, empty=1,
//     full=0, overflow=0.
//   - Buffer contents need not be cleared.
//   Handshake FSM (2 states, registered uart_go):
//   - LISTEN: uart_go=1. On uart_dr=1 -> capture uart_data, go to ACK.
//   - ACK: uart_go=0 for exactly one cycle, then back to LISTEN;
//     uart_dr is ignored while in ACK.
//   - Capture-to-go-high spacing is therefore 2 cycles. Each dr pulse
//     yields exactly one push attempt.
//   Push (in the LISTEN cycle where uart_dr=1):
//   - If not full, or full with rd=1 in the same cycle: write mem[wr_ptr],
//     then wr_ptr+1.
//   - If full with rd=0: drop the byte, set overflow. The handshake still
//     acknowledges (ACK state entered).
//   Pop (rd=1):
//   - If empty=0: rd_ptr+1.
//   - If empty=1: ignored; no pointer change and no error flag.
//   - Data popped is the dout value shown in the same cycle as rd.
//   Simultaneous push+pop:
//   - Both take effect.
//   - count unchanged, except when starting empty: the pop is ignored,
//     count 0->1.
//   Pointers and count:
//   - Pointers are DEPTH_BITWIDTH bits and wrap modulo 2^DEPTH_BITWIDTH
//     with no special case.
//   - count is updated +1, -1 or 0 per cycle and never leaves
//     0..2^DEPTH_BITWIDTH.
//   - empty = (count==0); full = (count==2^DEPTH_BITWIDTH). Both are
//     derived from registered count.
//   dout:
//   - Combinational from mem[rd_ptr] when empty=0, else 8'h00.
//   - A byte pushed in cycle N is visible on dout from cycle N+1.
//   overflow:
//   - Set by a drop, cleared by overflow_clr.
//   - If set and clear happen in the same cycle, set wins.
//   Reset mid-operation:
//   - rst during ACK returns the FSM to LISTEN (uart_go=1) immediately.
//   - All stored bytes are discarded (count=0).
// TESTING
//   1. Reset, then 3 UartRx bytes 8'h41,8'h42,8'h43, no rd:
//      -> count=3, dout=8'h41; uart_go low exactly 1 cycle per byte.
//   2. Then rd for 1 cycle per byte:
//      -> dout 41,42,43, then 00; empty=1; count=0.
//   3. Push 16 bytes 8'h00..8'h0F (DEPTH_BITWIDTH=4), then a 17th 8'hFF:
//      -> full=1, count=16, overflow=1, uart_go still pulses low once,
//         dout=8'h00.
//   4. Full FIFO, dr with 8'h55 and rd in the same cycle:
//      -> count stays 16, overflow unchanged; after 16 pops the last
//         byte read is 8'h55 (wrap-around path).
//   5. Empty FIFO, rd=1 together with a push of 8'h7E:
//      -> count=1, dout=8'h7E next cycle; the rd is ignored.
//   6. overflow=1, overflow_clr=1 together with a new drop:
//      -> overflow stays 1.
//      overflow_clr alone -> 0. rst during ACK -> uart_go=1, count=0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   Receive-side byte buffer between UartRx and the CPU-facing I/O register
//   file. It keeps the UartRx go/dr handshake running continuously. Each
//   received byte is stored in a circular FIFO, so bytes are not lost while
//   the CPU is busy. The reader sees first-word fall-through data, an empty
//   flag, a full flag, an entry count and a sticky overflow flag.
//
// Ports
//   clk           in   1      single clock, all state updates on posedge
//   rst           in   1      asynchronous, active-high reset
//   uart_data     in   8      byte from UartRx, valid while uart_dr=1
//   uart_dr       in   1      UartRx data ready
//   uart_go       out  1      to UartRx: 1 = receive, 0 = acknowledge dr
//   rd            in   1      pop head entry (one byte per asserted cycle)
//   dout          out  8      head entry (fall-through), 8'h00 when empty
//   empty         out  1      FIFO holds 0 entries
//   full          out  1      FIFO holds 2^DEPTH_BITWIDTH entries
//   count         out  DB+1   number of stored entries
//   overflow      out  1      sticky: a received byte was dropped
//   overflow_clr  in   1      clears overflow (a same-cycle drop wins)
//   dbg_state     out  1      handshake FSM state (0 = LISTEN, 1 = ACK)
//
// Handshake: UartRx raises uart_dr with a byte while uart_go=1. The byte is
// taken in that LISTEN cycle, and uart_go then drops for exactly one cycle
// (ACK). uart_dr is ignored during ACK, so each dr pulse gives exactly one
// push attempt.
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH_BITWIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                uart_data,
    input  logic                      uart_dr,
    output logic                      uart_go,
    input  logic                      rd,
    output logic [7:0]                dout,
    output logic                      empty,
    output logic                      full,
    output logic [DEPTH_BITWIDTH:0]   count,
    output logic                      overflow,
    input  logic                      overflow_clr,
    output logic [0:0]                dbg_state
);

    localparam int DEPTH = 1 << DEPTH_BITWIDTH;
    localparam logic [DEPTH_BITWIDTH:0] FULL_COUNT = (DEPTH_BITWIDTH + 1)'(DEPTH);

    localparam logic [0:0] S_LISTEN = 1'b0;
    localparam logic [0:0] S_ACK    = 1'b1;

    logic [0:0]                  state_q, state_d;
    logic                        go_q, go_d;
    logic [DEPTH_BITWIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITWIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITWIDTH:0]     count_q, count_d;
    logic                        overflow_q, overflow_d;
    logic [7:0]                  mem_q [DEPTH];

    logic                        push_attempt;
    logic                        do_push;
    logic                        do_pop;
    logic                        drop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_COUNT);

    // A full FIFO still accepts a byte when the same cycle pops one. The
    // write lands on the slot that is being read out, and dout shows the
    // old value until the clock edge.
    assign push_attempt = (state_q == S_LISTEN) && uart_dr;
    assign do_pop       = rd && !empty;
    assign do_push      = push_attempt && (!full || rd);
    assign drop         = push_attempt && full && !rd;

    always_comb begin
        state_d    = state_q;
        go_d       = go_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        case (state_q)
            S_LISTEN: begin
                if (uart_dr) begin
                    state_d = S_ACK;
                    go_d    = 1'b0;
                end
            end
            default: begin
                state_d = S_LISTEN;
                go_d    = 1'b1;
            end
        endcase

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + DEPTH_BITWIDTH'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_BITWIDTH'(1);
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (DEPTH_BITWIDTH + 1)'(1);
            2'b01:   count_d = count_q - (DEPTH_BITWIDTH + 1)'(1);
            default: count_d = count_q;
        endcase

        // A drop and a clear in the same cycle leave the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_LISTEN;
            go_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            go_q       <= go_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset. Stale contents are never visible because dout
    // is forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= uart_data;
        end
    end

    assign uart_go   = go_q;
    assign dout      = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign dbg_state = state_q;

endmodule
